// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle control FSM: major opcodes, ALU codes,
// decoded instruction classes and the FSM state encoding.
package cpu_ctrl_pkg;

    localparam logic [6:0] OpcRAlu   = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcHalt   = 7'b1111111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluXor = 4'b0100;
    localparam logic [3:0] AluSll = 4'b0101;
    localparam logic [3:0] AluSrl = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    typedef enum logic [2:0] {
        ClsRAlu, ClsIAlu, ClsLoad, ClsStore, ClsBranch, ClsHalt, ClsIllegal
    } instr_class_e;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational decode of a latched instruction word into class, ALU opcode
// and an illegal flag.
module instr_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  class_o,
    output logic [3:0]  opcode_o,
    output logic        illegal_o
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    always_comb begin
        class_o   = ClsIllegal;
        opcode_o  = AluAdd;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OpcRAlu:   class_o = ClsRAlu;
            OpcIAlu:   class_o = ClsIAlu;
            OpcLoad:   class_o = ClsLoad;
            OpcStore:  class_o = ClsStore;
            OpcBranch: class_o = ClsBranch;
            OpcHalt:   class_o = ClsHalt;
            default:   illegal_o = 1'b1;
        endcase

        if (class_o == ClsRAlu || class_o == ClsIAlu) begin
            case (instr_i[14:12])
                3'b000:  opcode_o = (class_o == ClsRAlu && instr_i[30]) ? AluSub : AluAdd;
                3'b001:  opcode_o = AluSll;
                3'b010:  opcode_o = AluSlt;
                3'b100:  opcode_o = AluXor;
                3'b101:  opcode_o = AluSrl;
                3'b110:  opcode_o = AluOr;
                3'b111:  opcode_o = AluAnd;
                default: illegal_o = 1'b1;
            endcase
        end else if (class_o == ClsBranch) begin
            opcode_o = AluSub;
            // Only BEQ (000) and BNE (001) are supported.
            illegal_o = (instr_i[14:13] != 2'b00);
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define INSTR_COUNT_EN to enable the retired-instruction counter.
module control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic [3:0]  opcode_o,
    output logic        alu_src_o,
    output logic        reg_write_o,
    output logic        mem_rw_o,
    output logic        mem_to_reg_o,
    output logic        pc_src_o,
    output logic        pc_en_o,
    output logic        busy_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic        taken_q;
    logic        illegal_q;
    logic [2:0]  dec_class;
    logic [3:0]  dec_opcode;
    logic        dec_illegal;
    logic        in_alu;
    logic        is_mem;

    instr_class_decoder u_decoder (
        .instr_i   (instr_q),
        .class_o   (dec_class),
        .opcode_o  (dec_opcode),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch) begin
                instr_q <= instr_i;
            end
            // instr[12] distinguishes BNE from BEQ.
            if (state_q == StExec) begin
                taken_q <= instr_q[12] ? ~zero_i : zero_i;
            end
            if (state_q == StDecode && dec_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign is_mem = (dec_class == ClsLoad) || (dec_class == ClsStore);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = (dec_illegal || dec_class == ClsHalt) ? StHalt : StExec;
            StExec:   state_d = is_mem ? StMem : StWb;
            StMem:    if (mem_ready_i) state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_alu       = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
        opcode_o     = in_alu ? dec_opcode : 4'b0000;
        alu_src_o    = in_alu && (dec_class == ClsIAlu || is_mem);
        mem_rw_o     = (state_q == StMem) && (dec_class == ClsStore);
        mem_to_reg_o = (state_q == StMem || state_q == StWb) && (dec_class == ClsLoad);
        reg_write_o  = (state_q == StWb)
                       && (dec_class == ClsRAlu || dec_class == ClsIAlu || dec_class == ClsLoad);
        pc_en_o      = (state_q == StWb);
        pc_src_o     = (state_q == StWb) && (dec_class == ClsBranch) && taken_q;
        busy_o       = (state_q != StIdle) && (state_q != StHalt);
        illegal_o    = illegal_q;
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q <= '0;
        end else if (state_q == StWb) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_o = retired_q;
`else
    assign retired_o = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instruction scenarios with a
// scoreboard of expected write-back observations.
module tb_control_fsm;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] instr_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic [3:0]  opcode_o;
    logic        alu_src_o;
    logic        reg_write_o;
    logic        mem_rw_o;
    logic        mem_to_reg_o;
    logic        pc_src_o;
    logic        pc_en_o;
    logic        busy_o;
    logic        illegal_o;
    logic [31:0] retired_o;

    typedef struct packed {
        logic [4:0] lat;
        logic [3:0] opcode;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic [3:0] rw_cnt;
        logic [3:0] mrw_cnt;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef INSTR_COUNT_EN
    localparam logic [31:0] RetiredAfter3 = 32'd3;
`else
    localparam logic [31:0] RetiredAfter3 = 32'd0;
`endif

    control_fsm dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .instr_i      (instr_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .opcode_o     (opcode_o),
        .alu_src_o    (alu_src_o),
        .reg_write_o  (reg_write_o),
        .mem_rw_o     (mem_rw_o),
        .mem_to_reg_o (mem_to_reg_o),
        .pc_src_o     (pc_src_o),
        .pc_en_o      (pc_en_o),
        .busy_o       (busy_o),
        .illegal_o    (illegal_o),
        .retired_o    (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic res_t mk(input int lat, input logic [3:0] opc, input logic asrc,
                                input logic rw, input logic m2r, input logic psrc,
                                input int rwc, input int mrwc);
        res_t r;
        r.lat = 5'(lat); r.opcode = opc; r.alu_src = asrc; r.reg_write = rw;
        r.mem_to_reg = m2r; r.pc_src = psrc; r.rw_cnt = 4'(rwc); r.mrw_cnt = 4'(mrwc);
        return r;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0; start_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Runs one instruction; called at a negedge. Cycle 1 is FETCH. mem_ready is held
    // low for 'w' MEM cycles. Captures outputs in the pc_en cycle; lat=0 on timeout.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int w,
                             input bit do_start, output res_t r);
        r = '0;
        instr_i = ins; zero_i = z; mem_ready_i = 1'b0;
        if (do_start) start_i = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (reg_write_o) r.rw_cnt = r.rw_cnt + 4'd1;
            if (mem_rw_o) r.mrw_cnt = r.mrw_cnt + 4'd1;
            mem_ready_i = (k >= 4 + w);
            if (pc_en_o) begin
                r.lat = 5'(k); r.opcode = opcode_o; r.alu_src = alu_src_o;
                r.reg_write = reg_write_o; r.mem_to_reg = mem_to_reg_o; r.pc_src = pc_src_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        instr_i = 32'h002081B3; zero_i = 1'b1; mem_ready_i = 1'b1; start_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({opcode_o, alu_src_o, reg_write_o, mem_rw_o, mem_to_reg_o, pc_src_o, pc_en_o,
             busy_o, illegal_o, retired_o} !== 44'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got op=%h busy=%b ill=%b ret=%h expected all zero",
                     opcode_o, busy_o, illegal_o, retired_o);
        end
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL idle_without_start: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_r_alu();
        res_t got, exp;
        do_reset();
        exp_q.push_back(mk(4, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
        run_instr(32'h002081B3, 1'b0, 0, 1'b1, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL r_alu_add: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_load();
        res_t got, exp;
        do_reset();
        exp_q.push_back(mk(8, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0));
        run_instr(32'h0000A103, 1'b0, 3, 1'b1, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL load_wait3: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_branch();
        res_t got, exp;
        do_reset();
        exp_q.push_back(mk(4, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        exp_q.push_back(mk(4, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        exp_q.push_back(mk(4, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        run_instr(32'h00208463, 1'b1, 0, 1'b1, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL beq_taken: got %h expected %h", got, exp);
        end
        run_instr(32'h00208463, 1'b0, 0, 1'b0, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL beq_not_taken: got %h expected %h", got, exp);
        end
        run_instr(32'h00209463, 1'b0, 0, 1'b0, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL bne_taken: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        do_reset();
        instr_i = 32'h0000007B; start_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_i = 1'b0;
            if (pc_en_o || reg_write_o || mem_rw_o) pulses++;
        end
        n_cmp++;
        if ({busy_o, illegal_o} !== 2'b01) begin
            n_bad++; $display("FAIL illegal_halt: busy/illegal got %b%b expected 01", busy_o, illegal_o);
        end
        start_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start_i = 1'b0;
            if (pc_en_o || reg_write_o || mem_rw_o) pulses++;
        end
        n_cmp++;
        if ({busy_o, illegal_o} !== 2'b01) begin
            n_bad++; $display("FAIL halt_ignores_start: busy/illegal got %b%b expected 01", busy_o, illegal_o);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL illegal_no_pulses: got %0d pulses expected 0", pulses);
        end
        // A HALT instruction stops the FSM without flagging illegal.
        do_reset();
        instr_i = 32'h0000007F; start_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        n_cmp++;
        if ({busy_o, illegal_o, pc_en_o} !== 3'b000) begin
            n_bad++; $display("FAIL halt_instr: busy/illegal/pc_en got %b%b%b expected 000", busy_o, illegal_o, pc_en_o);
        end
    endtask

    task automatic test_store_reset();
        int pulses = 0;
        do_reset();
        instr_i = 32'h0020A023; zero_i = 1'b0; mem_ready_i = 1'b0; start_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        n_cmp++;
        if ({mem_rw_o, alu_src_o, busy_o} !== 3'b111) begin
            n_bad++; $display("FAIL store_mem: memrw/alusrc/busy got %b%b%b expected 111", mem_rw_o, alu_src_o, busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({opcode_o, alu_src_o, reg_write_o, mem_rw_o, mem_to_reg_o, pc_src_o, pc_en_o,
             busy_o, illegal_o, retired_o} !== 44'h0) begin
            n_bad++;
            $display("FAIL mid_store_reset: got op=%h memrw=%b busy=%b expected all zero",
                     opcode_o, mem_rw_o, busy_o);
        end
        @(negedge clk);
        rst_ni = 1'b1; mem_ready_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (pc_en_o || reg_write_o || mem_rw_o || busy_o) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL abort_no_pulses: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        do_reset();
        exp_q.push_back(mk(4, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0));
        exp_q.push_back(mk(4, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
        exp_q.push_back(mk(5, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1));
        run_instr(32'h00004093, 1'b0, 0, 1'b1, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL b2b_xori: got %h expected %h", got, exp);
        end
        run_instr(32'h40000033, 1'b0, 0, 1'b0, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL b2b_sub: got %h expected %h", got, exp);
        end
        run_instr(32'h0020A023, 1'b0, 0, 1'b0, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++; $display("FAIL b2b_store: got %h expected %h", got, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (retired_o !== RetiredAfter3) begin
            n_bad++; $display("FAIL retired_count: got %0d expected %0d", retired_o, RetiredAfter3);
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; instr_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        test_reset();
        test_r_alu();
        test_load();
        test_branch();
        test_illegal();
        test_store_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; state forced to IDLE.
REQ-004 start  input  1  one-cycle pulse; leaves IDLE.
REQ-005 instr  input  32  fetched instruction word from instruction ROM.
REQ-006 zero  input  1  ALU zero flag (ALU status bit 2).
REQ-007 mem_ready  input  1  data RAM access complete.
REQ-008 opcode  output  4  ALU operation code.
REQ-009 ALUsrc  output  1  0 = register operand, 1 = immediate.
REQ-010 RegWrite  output  1  register-file write enable.
REQ-011 MemRW  output  1  1 = RAM write.
REQ-012 MemtoReg  output  1  1 = writeback from RAM, 0 = from ALU.
REQ-013 PCsrc  output  1  1 = branch target, 0 = PC+4.
REQ-014 pc_en  output  1  PC register load enable.
REQ-015 busy  output  1  high in any state except IDLE and HALT.
REQ-016 illegal  output  1  sticky; undecodable instruction seen.
REQ-017 retired  output  32  retired-instruction count.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE->FETCH on start.
- FETCH->DECODE.
- DECODE->EXEC, or ->HALT when illegal/halt.
- EXEC->MEM for load/store, else ->WB.
- MEM->WB when mem_ready, else hold.
- WB->FETCH.
- HALT is terminal until reset.
REQ-019 SHALL latch instr in FETCH and decode it only from the latched copy.
REQ-020 SHALL decode instr[6:0] as follows:
- 0110011 R-ALU.
- 0010011 I-ALU.
- 0000011 LOAD.
- 0100011 STORE.
- 1100011 BRANCH.
- 1111111 HALT (not illegal).
- All other values are illegal.
REQ-021 SHALL map funct3 instr[14:12] to opcode as follows:
- 000 -> ADD 0000, or SUB 0001 when R-ALU and instr[30]=1.
- 001 -> SLL 0101.
- 010 -> SLT 0111.
- 100 -> XOR 0100.
- 101 -> SRL 0110.
- 110 -> OR 0011.
- 111 -> AND 0010.
- 011 is illegal for ALU classes.
- LOAD/STORE force ADD; BRANCH forces SUB.
REQ-022 BRANCH funct3 000 (BEQ) and 001 (BNE) SHALL be the only legal branch codes.
REQ-023 ALUsrc SHALL be 1 for I-ALU, LOAD and STORE in EXEC/MEM/WB, else 0.
REQ-024 zero SHALL be sampled and registered at the end of EXEC; taken = zero for BEQ, !zero for BNE.
REQ-025 MemRW SHALL be 1 only in MEM for STORE; MemtoReg SHALL be 1 only in MEM/WB for LOAD.
REQ-026 RegWrite SHALL pulse exactly one cycle in WB for R-ALU, I-ALU and LOAD, never for STORE or BRANCH.
REQ-027 pc_en SHALL pulse exactly one cycle in WB; PCsrc = taken during that cycle for BRANCH, else 0.
REQ-028 Latency SHALL be 4 cycles (FETCH..WB) for ALU/branch, and 5 + mem_ready wait cycles for LOAD/STORE.
REQ-029 On entering HALT, pc_en, RegWrite and MemRW SHALL be 0 and stay 0; illegal is set only for illegal decode; start is ignored.
REQ-030 start SHALL be ignored outside IDLE.

Reset
REQ-031 While reset=0, state SHALL be IDLE and all outputs 0, including opcode=0000, illegal=0 and retired=0.
REQ-032 Reset asserted mid-instruction SHALL abort it with no further RegWrite, MemRW or pc_en pulse.

Configuration
REQ-033 With INSTR_COUNT_EN defined, retired SHALL increment by 1 on each WB cycle and wrap from FFFFFFFF to 0.
REQ-034 Without INSTR_COUNT_EN, the retired port SHALL remain present and be constant 0.

Structure
REQ-035 Major-opcode constants, ALU opcode codes and the state encoding SHALL live in shared package cpu_ctrl_pkg.
REQ-036 Combinational decode SHALL be sub-module instr_class_decoder (instr -> class, ALU opcode, illegal); the FSM stays in control_fsm.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Reset, start, then R-ALU ADD instr 0x002081B3 -> opcode 0000, RegWrite pulse in cycle 4, pc_en with PCsrc=0 in cycle 4.
- LOAD 0x0000A103 with mem_ready low for 3 cycles -> MEM held 3 extra cycles, MemtoReg=1, RegWrite in WB, latency 8.
- BEQ 0x00208463 with zero=1 in EXEC -> opcode 0001, RegWrite=0, pc_en=1 with PCsrc=1; with zero=0 -> PCsrc=0.
- Illegal instr 0x0000007B -> HALT after DECODE, illegal=1, no pc_en; subsequent start ignored.
- Reset pulsed low during MEM of a STORE -> immediate IDLE, MemRW=0, all outputs 0.
- With INSTR_COUNT_EN, 3 instructions retired -> retired=3; without the macro -> retired=0.
